tron_seq_controller: RTL

- Parametrised multicycle control FSM for the Tron 16-bit datapath; successor to the current fixed-timing controller.
- Adds an instruction-fetch handshake and variable-latency data-memory handshakes (ready-based, with wait-state timeout).
- Adds a holding instruction register, an explicit shift-direction decode, an illegal-opcode trap and an external stall.
- Sits between the instruction/data memory ports and the regfile/ALU/shifter/PC muxes.

---
 rtl/tron_seq_controller_if.sv | 43 ++++
 rtl/tron_seq_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tron_seq_controller_if.sv
// Interface bundling the Tron controller's memory handshakes, decode fields and datapath strobes.
// The controller connects through the master modport; the datapath/memory side uses slave.
interface tron_seq_controller_if #(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4
);
    logic               stall;
    logic               imemReady;
    logic [15:0]        instruction;
    logic               dmemReady;
    logic               imemReq;
    logic               dmemReq;
    logic               memWrite;
    logic [REGBITS-1:0] regAddA;
    logic [REGBITS-1:0] regAddB;
    logic [WIDTH-1:0]   immediate;
    logic [3:0]         flagOp;
    logic [3:0]         ALUOp;
    logic [1:0]         shiftOp;
    logic [2:0]         busOp;
    logic               immMUX;
    logic               regWrite;
    logic               flagWrite;
    logic               pcAdd;
    logic               pcJump;
    logic               pcBranch;
    logic               fault;
    logic [1:0]         faultCause;

    modport master (
        input  stall, imemReady, instruction, dmemReady,
        output imemReq, dmemReq, memWrite, regAddA, regAddB, immediate,
               flagOp, ALUOp, shiftOp, busOp, immMUX, regWrite, flagWrite,
               pcAdd, pcJump, pcBranch, fault, faultCause
    );

    modport slave (
        output stall, imemReady, instruction, dmemReady,
        input  imemReq, dmemReq, memWrite, regAddA, regAddB, immediate,
               flagOp, ALUOp, shiftOp, busOp, immMUX, regWrite, flagWrite,
               pcAdd, pcJump, pcBranch, fault, faultCause
    );
endinterface

// File: rtl/tron_seq_controller.sv
// Multicycle control FSM for the Tron 16-bit datapath: fetch/data handshakes with wait timeout,
// holding instruction register, illegal-opcode trap and external stall.
module tron_seq_controller #(
    parameter int WIDTH      = 16,
    parameter int REGBITS    = 4,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    tron_seq_controller_if.master bus
);
    localparam int         FB        = (REGBITS < 4) ? REGBITS : 4;
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);
    localparam logic [3:0] OP_CMP    = 4'b1011;
    localparam logic [3:0] OP_MOV    = 4'b1101;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_SHIFT, S_LUI1, S_LUI2,
        S_MEM_LD, S_MEM_ST, S_JAL1, S_JCOND, S_BCOND, S_TRAP
    } state_e;

    state_e           state_q, state_d;
    logic [15:0]      ir_q, ir_d;
    logic [WIDTH-1:0] imm_q, imm_d;
    logic [7:0]       wait_q, wait_d;
    logic             fault_q, fault_d;
    logic [1:0]       cause_q, cause_d;

    logic [3:0] hi, ext, alu_code;
    logic       mem_done;

    assign hi       = ir_q[15:12];
    assign ext      = ir_q[7:4];
    assign alu_code = (state_q == S_EXEC_R) ? ext : hi;
    assign mem_done = bus.dmemReady & ~bus.stall;

    function automatic logic is_alu(input logic [3:0] c);
        return c inside {4'b0101, 4'b1001, 4'b1011, 4'b0001, 4'b0010, 4'b0011, 4'b1101};
    endfunction

    function automatic logic [3:0] alu_fn(input logic [3:0] c);
        logic [3:0] f;
        case (c)
            4'b0101, 4'b1101: f = 4'b0000;
            4'b1001, 4'b1011: f = 4'b1000;
            default:          f = {2'b00, c[1:0]};
        endcase
        return f;
    endfunction

    function automatic state_e decode_target(input logic [3:0] h, input logic [3:0] e);
        state_e t;
        t = S_TRAP;
        case (h)
            4'b0000: if (is_alu(e)) t = S_EXEC_R;
            4'b1111: t = S_LUI1;
            4'b1000: if (e == 4'b0100 || e[3:1] == 3'b000) t = S_SHIFT;
            4'b0100: begin
                case (e)
                    4'b0000: t = S_MEM_LD;
                    4'b0100: t = S_MEM_ST;
                    4'b1000: t = S_JAL1;
                    4'b1100: t = S_JCOND;
                    default: t = S_TRAP;
                endcase
            end
            4'b1100: t = S_BCOND;
            default: if (is_alu(h)) t = S_EXEC_I;
        endcase
        return t;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            imm_q   <= '0;
            wait_q  <= '0;
            fault_q <= 1'b0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            imm_q   <= imm_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        imm_d   = imm_q;
        wait_d  = wait_q;
        fault_d = fault_q;
        cause_d = cause_q;
        if (!bus.stall) begin
            case (state_q)
                S_FETCH: begin
                    if (bus.imemReady) begin
                        ir_d    = bus.instruction;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (hi inside {4'b0101, 4'b1001, 4'b1011, 4'b1100})
                        imm_d = {{(WIDTH-8){ir_q[7]}}, ir_q[7:0]};
                    else if (hi == 4'b1000 && ext[3:1] == 3'b000)
                        imm_d = {{(WIDTH-4){1'b0}}, ir_q[3:0]};
                    else
                        imm_d = {{(WIDTH-8){1'b0}}, ir_q[7:0]};
                    state_d = decode_target(hi, ext);
                    if (state_d == S_TRAP) begin
                        fault_d = 1'b1;
                        cause_d = 2'b01;
                    end
                end
                S_LUI1: begin
                    imm_d   = WIDTH'(8);
                    state_d = S_LUI2;
                end
                S_JAL1: state_d = S_JCOND;
                // Ready is tested before the limit so a completion on the last allowed cycle wins.
                S_MEM_LD, S_MEM_ST: begin
                    if (bus.dmemReady) begin
                        wait_d  = '0;
                        state_d = S_FETCH;
                    end else if (wait_q == WAIT_LAST) begin
                        wait_d  = '0;
                        fault_d = 1'b1;
                        cause_d = 2'b10;
                        state_d = S_TRAP;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
                S_TRAP:  state_d = S_TRAP;
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign bus.regAddA    = REGBITS'(ir_q[FB-1:0]);
    assign bus.regAddB    = REGBITS'(ir_q[8+FB-1:8]);
    assign bus.immediate  = imm_q;
    assign bus.fault      = fault_q;
    assign bus.faultCause = cause_q;

    always_comb begin
        bus.imemReq   = 1'b0;
        bus.dmemReq   = 1'b0;
        bus.memWrite  = 1'b0;
        bus.flagOp    = 4'b0000;
        bus.ALUOp     = 4'b0000;
        bus.shiftOp   = 2'b00;
        bus.busOp     = 3'b000;
        bus.immMUX    = 1'b0;
        bus.regWrite  = 1'b0;
        bus.flagWrite = 1'b0;
        bus.pcAdd     = 1'b0;
        bus.pcJump    = 1'b0;
        bus.pcBranch  = 1'b0;
        case (state_q)
            S_FETCH: bus.imemReq = 1'b1;
            S_EXEC_R, S_EXEC_I: begin
                bus.immMUX    = (state_q == S_EXEC_I);
                bus.regWrite  = (alu_code != OP_CMP);
                bus.flagWrite = (alu_code != OP_MOV);
                bus.pcAdd     = 1'b1;
                bus.ALUOp     = alu_fn(alu_code);
                if (alu_code == OP_MOV) bus.busOp = 3'b010;
            end
            S_SHIFT: begin
                bus.busOp    = 3'b001;
                bus.regWrite = 1'b1;
                bus.pcAdd    = 1'b1;
                if (ext != 4'b0100) begin
                    bus.immMUX  = 1'b1;
                    bus.shiftOp = {1'b0, ir_q[4]};
                end
            end
            S_LUI1: begin
                bus.immMUX   = 1'b1;
                bus.busOp    = 3'b010;
                bus.regWrite = 1'b1;
            end
            S_LUI2: begin
                bus.immMUX   = 1'b1;
                bus.busOp    = 3'b001;
                bus.regWrite = 1'b1;
                bus.pcAdd    = 1'b1;
            end
            S_MEM_LD: begin
                bus.dmemReq = 1'b1;
                if (mem_done) begin
                    bus.busOp    = 3'b011;
                    bus.regWrite = 1'b1;
                    bus.pcAdd    = 1'b1;
                end
            end
            S_MEM_ST: begin
                bus.dmemReq  = 1'b1;
                bus.memWrite = 1'b1;
                bus.busOp    = 3'b101;
                bus.pcAdd    = mem_done;
            end
            S_JAL1: begin
                bus.regWrite = 1'b1;
                bus.busOp    = 3'b100;
                bus.pcAdd    = 1'b1;
                bus.flagOp   = 4'b1111;
            end
            S_JCOND: begin
                bus.pcJump = 1'b1;
                bus.flagOp = ir_q[11:8];
            end
            S_BCOND: begin
                bus.pcBranch = 1'b1;
                bus.immMUX   = 1'b1;
                bus.flagOp   = ir_q[11:8];
            end
            default: ;
        endcase
        // Reset gating makes the request/strobes fall asynchronously, not just at the next edge.
        if (reset || bus.stall) begin
            bus.imemReq   = 1'b0;
            bus.dmemReq   = 1'b0;
            bus.memWrite  = 1'b0;
            bus.regWrite  = 1'b0;
            bus.flagWrite = 1'b0;
            bus.pcAdd     = 1'b0;
            bus.pcJump    = 1'b0;
            bus.pcBranch  = 1'b0;
        end
    end
endmodule
